// File: rtl/sev_seg_pkg.sv
// Shared constants and floor encoding for the elevator status display.
package sev_seg_pkg;

    // Active-low glyphs: bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_DOOR_OPEN   = 7'b1000011;
    localparam logic [6:0] SEG_DOOR_CLOSED = 7'b0100011;
    localparam logic [6:0] SEG_BLANK       = 7'b1111111;
    localparam logic [3:0] SEL_NONE        = 4'b1111;

    typedef enum logic [1:0] {
        FLOOR_1 = 2'd0,
        FLOOR_2 = 2'd1,
        FLOOR_3 = 2'd2,
        FLOOR_4 = 2'd3
    } floor_t;

endpackage

// File: rtl/floor_digit_decoder.sv
// Combinational floor index to active-low one-hot digit enable.
module floor_digit_decoder
    import sev_seg_pkg::*;
(
    input  logic [1:0] floor_i,
    output logic [3:0] select_o
);

    always_comb begin
        select_o = SEL_NONE;
        case (floor_t'(floor_i))
            FLOOR_1: select_o = 4'b1110;
            FLOOR_2: select_o = 4'b1101;
            FLOOR_3: select_o = 4'b1011;
            FLOOR_4: select_o = 4'b0111;
            default: select_o = SEL_NONE;
        endcase
    end

endmodule

// File: rtl/sev_seg_display.sv
// Registered seven-segment status driver: floor selects the digit, door picks the glyph.
module sev_seg_display
    import sev_seg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] floorSel,
    input  logic       door,
    output logic [6:0] segments,
    output logic [3:0] select
);

    logic [3:0] select_d, select_q;
    logic [6:0] segments_d, segments_q;
    logic [3:0] decoded_sel;

    floor_digit_decoder u_decoder (
        .floor_i  (floorSel),
        .select_o (decoded_sel)
    );

    always_comb begin
        select_d   = decoded_sel;
        segments_d = door ? SEG_DOOR_OPEN : SEG_DOOR_CLOSED;
    end

    // Both outputs share one register stage so floor and door changes land together.
    always_ff @(posedge clk) begin
        if (reset) begin
            select_q   <= SEL_NONE;
            segments_q <= SEG_BLANK;
        end else begin
            select_q   <= select_d;
            segments_q <= segments_d;
        end
    end

    assign select   = select_q;
    assign segments = segments_q;

endmodule

// File: tb/tb_sev_seg_display.sv
// Self-checking bench: directed vector table, latency sequence, randomized model check.
module tb_sev_seg_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] floorSel;
    logic       door;
    logic [6:0] segments;
    logic [3:0] select;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [1:0] fl;
        logic       dr;
        logic [3:0] exp_sel;
        logic [6:0] exp_seg;
        string      name;
    } vec_t;

    vec_t vecs[$];

    sev_seg_display dut (
        .clk      (clk),
        .reset    (reset),
        .floorSel (floorSel),
        .door     (door),
        .segments (segments),
        .select   (select)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] es, input logic [6:0] eg);
        total++;
        if (select !== es || segments !== eg) begin
            bad++;
            $display("FAIL %s: got select=%b segments=%b, expected select=%b segments=%b",
                     name, select, segments, es, eg);
        end
    endtask

    // Drive one cycle of inputs between edges, then settle just past the rising edge.
    task automatic step(input logic r, input logic [1:0] f, input logic d);
        @(negedge clk);
        reset    = r;
        floorSel = f;
        door     = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: segment lists of lit segments, active-low arithmetic.
    function automatic logic [3:0] model_sel(input logic r, input int unsigned f);
        if (r) return 4'd15;
        return 4'(15 - (1 << f));
    endfunction

    function automatic logic [6:0] model_seg(input logic r, input logic d);
        int unsigned lit;
        if (r) return 7'd127;
        // open: c,d,e,f lit ; closed: c,d,e,g lit
        lit = d ? ((1 << 2) + (1 << 3) + (1 << 4) + (1 << 5))
                : ((1 << 2) + (1 << 3) + (1 << 4) + (1 << 6));
        return 7'(127 - lit);
    endfunction

    initial begin
        reset    = 1'b1;
        floorSel = 2'd2;
        door     = 1'b1;

        vecs.push_back('{1'b1, 2'd2, 1'b1, 4'b1111, 7'b1111111, "reset_1"});
        vecs.push_back('{1'b1, 2'd2, 1'b1, 4'b1111, 7'b1111111, "reset_2"});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 4'b1110, 7'b1000011, "open_f0"});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 4'b1101, 7'b1000011, "open_f1"});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 4'b1011, 7'b1000011, "open_f2"});
        vecs.push_back('{1'b0, 2'd3, 1'b1, 4'b0111, 7'b1000011, "open_f3"});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 4'b1110, 7'b0100011, "closed_f0"});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 4'b1101, 7'b0100011, "closed_f1"});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 4'b1011, 7'b0100011, "closed_f2"});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 4'b0111, 7'b0100011, "closed_f3"});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 4'b1110, 7'b0100011, "simul_pre"});
        vecs.push_back('{1'b0, 2'd3, 1'b1, 4'b0111, 7'b1000011, "simul_both"});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 4'b1101, 7'b0100011, "midrst_pre"});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 4'b1111, 7'b1111111, "midrst_blank"});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 4'b1101, 7'b0100011, "midrst_release"});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].dr);
            check(vecs[i].name, vecs[i].exp_sel, vecs[i].exp_seg);
        end

        // Latency: door change between edges must not reach the outputs early.
        step(1'b0, 2'd3, 1'b1);
        check("lat_setup", 4'b0111, 7'b1000011);
        @(negedge clk);
        door = 1'b0;
        #2;
        check("lat_hold", 4'b0111, 7'b1000011);
        @(posedge clk);
        #1;
        check("lat_update", 4'b0111, 7'b0100011);

        // Randomized sweep with occasional reset.
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [1:0] f;
            logic       d;
            r = ($urandom_range(0, 9) == 0);
            f = 2'($urandom_range(0, 3));
            d = 1'($urandom_range(0, 1));
            step(r, f, d);
            check($sformatf("rand_%0d", i), model_sel(r, int'(f)), model_seg(r, d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sev_seg_display.md
# sev_seg_display

Registered seven-segment status driver for the elevator controller. It takes the current floor index and the door state, enables the single digit position that corresponds to the floor, and drives a door-state glyph onto the shared segment lines. It sits between the elevator control FSM and the board's 4-digit common-anode display.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears the display to blank
- floorSel  input  2  current floor index: 0 = floor one … 3 = floor four
- door  input  1  1 = door open, 0 = door closed
- segments  output  7  active-low segment drive; bit0 = a, bit1 = b, … bit6 = g
- select  output  4  active-low digit enable; bit n enables digit n

## Operation
- Digit select is one-hot active-low, indexed by floorSel:
  - 0 → 4'b1110
  - 1 → 4'b1101
  - 2 → 4'b1011
  - 3 → 4'b0111
- Exactly one digit is enabled at any time outside reset.
- Segment glyph depends only on door; floorSel does not affect it:
  - door = 1 (open) → 7'b1000011, segments c, d, e, f lit
  - door = 0 (closed) → 7'b0100011, segments c, d, e, g lit (lowercase "o")
- No multiplex scanning: the selected digit is held statically.
- All four floorSel values are legal. There is no invalid-input case.
- Unknown or X inputs are not filtered. No special handling.

## Timing
- Both outputs are registered, so there is no combinational path from input to output.
- Latency is 1 clock. Inputs sampled at rising edge N appear on the outputs after edge N, and hold until the next edge.
- Reset value, applied at the first rising edge with reset = 1:
  - select = 4'b1111 (all digits off)
  - segments = 7'b1111111 (all segments off)
- Reset has priority over input sampling. Asserting reset in any cycle forces blank on that edge, regardless of floorSel or door.
- After reset deasserts, the first rising edge with reset = 0 loads the decoded inputs.
- Simultaneous change of floorSel and door in one cycle: both outputs update together on the same edge. No intermediate mixed state is visible.
- Inputs are held between edges; no glitch appears on the outputs.

## Structure
- Shared package sev_seg_pkg holds:
  - SEG_DOOR_OPEN = 7'b1000011
  - SEG_DOOR_CLOSED = 7'b0100011
  - SEG_BLANK = 7'b1111111
  - SEL_NONE = 4'b1111
  - a floor_t enum (FLOOR_1 … FLOOR_4) for the 2-bit floorSel encoding, reused by the controller FSM
- One combinational sub-module, floor_digit_decoder: 2-bit floor in, active-low 4-bit select out.
- The top level contains:
  - the door-glyph mux
  - the output register pair for select and segments, with synchronous reset

## Test plan
- Reset: hold reset = 1 for 2 clocks with floorSel = 2, door = 1 → select = 4'b1111, segments = 7'b1111111 after the first edge.
- Floor sweep, door open: release reset, then apply floorSel = 0, 1, 2, 3 with door = 1, one value per clock. One clock later select = 1110, 1101, 1011, 0111 respectively; segments = 1000011 throughout.
- Floor sweep, door closed: same sequence with door = 0 → same select values; segments = 0100011 throughout.
- Latency: change door 1 → 0 between edges at floorSel = 3.
  - Outputs keep 0111 / 1000011 until the next rising edge.
  - Then they show 0111 / 0100011.
- Simultaneous change: floorSel 0 → 3 and door 0 → 1 in the same cycle → one edge later select = 0111 and segments = 1000011 together.
- Mid-operation reset: at floorSel = 1, door = 0, assert reset for one clock → blank output on that edge. Release → 1101 / 0100011 on the next edge.
